imem_fetch_ctrl: RTL and testbench

//  Fetch sequencer and port arbiter for the single-read-port instruction memory (10-bit word address, 32-bit data, combinational read).

---
 rtl/imem_fetch_ctrl_pkg.sv | 19 +
 rtl/imem_fetch_ctrl_if.sv | 36 +++
 rtl/imem_fetch_ctrl_fetch_buf.sv | 54 +++++
 rtl/imem_fetch_ctrl.sv | 107 ++++++++++
 tb/tb_imem_fetch_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM states, arbiter
// grant codes and PC constants.
package imem_fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   typedef enum logic {
      GNT_FETCH = 1'b0,
      GNT_DBG   = 1'b1
   } gnt_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Signal bundle between the fetch controller and its surroundings:
// instruction-memory port, decode handshake, control inputs and debug reader.
interface imem_fetch_ctrl_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_data;
   logic              halt;
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic              inst_valid;
   logic              inst_ready;
   logic [DATA_W-1:0] inst_data;
   logic [31:0]       inst_pc;
   logic [31:0]       fetch_pc;
   logic              dbg_req;
   logic [ADDR_W-1:0] dbg_addr;
   logic              dbg_gnt;
   logic              dbg_rvalid;
   logic [DATA_W-1:0] dbg_rdata;

   modport master (
      output imem_addr, inst_valid, inst_data, inst_pc, fetch_pc,
             dbg_gnt, dbg_rvalid, dbg_rdata,
      input  imem_data, halt, redirect_valid, redirect_pc, inst_ready,
             dbg_req, dbg_addr
   );

   modport slave (
      input  imem_addr, inst_valid, inst_data, inst_pc, fetch_pc,
             dbg_gnt, dbg_rvalid, dbg_rdata,
      output imem_data, halt, redirect_valid, redirect_pc, inst_ready,
             dbg_req, dbg_addr
   );
endinterface

// File: rtl/imem_fetch_ctrl_fetch_buf.sv
// DEPTH-entry FIFO holding fetched {pc, instruction} pairs for decode.
// Flush empties it in one cycle; enqueue into an empty buffer is not bypassed.
module fetch_buf #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     enq,
   input  logic                     deq,
   input  logic [31:0]              enq_pc,
   input  logic [DATA_W-1:0]        enq_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     head_valid,
   output logic [31:0]              head_pc,
   output logic [DATA_W-1:0]        head_data
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [31:0]       pc_mem   [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]   <= '0;
            data_mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) begin
            pc_mem[wr_ptr]   <= enq_pc;
            data_mem[wr_ptr] <= enq_data;
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(enq) - CNT_W'(deq);
      end
   end

   assign head_valid = (count != '0);
   assign head_pc    = pc_mem[rd_ptr];
   assign head_data  = data_mem[rd_ptr];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, fills the fetch buffer and shares
// the single memory read port with a debug reader by alternating under contention.
module imem_fetch_ctrl
   import imem_fetch_ctrl_pkg::*;
#(
   parameter int          ADDR_W   = 10,
   parameter int          DATA_W   = 32,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          DEPTH    = 2
) (
   input logic              clk,
   input logic              rst,
   imem_fetch_ctrl_if.master bus
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   state_t             state, state_nxt;
   gnt_t               last_gnt;
   logic [31:0]        pc;
   logic [31:0]        redirect_aligned;
   logic [CNT_W-1:0]   count;
   logic               head_valid;
   logic [31:0]        head_pc;
   logic [DATA_W-1:0]  head_data;
   logic               deq, buf_deq, fetch_want, contended;
   logic               fetch_gnt, dbg_gnt;
   logic               dbg_rvalid;
   logic [DATA_W-1:0]  dbg_rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_BOOT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_BOOT: state_nxt = ST_RUN;
         ST_RUN:  if (bus.halt)  state_nxt = ST_HALT;
         ST_HALT: if (!bus.halt) state_nxt = ST_RUN;
         default: state_nxt = ST_BOOT;
      endcase
   end

   assign deq        = head_valid & bus.inst_ready;
   assign buf_deq    = deq & ~bus.redirect_valid;
   assign fetch_want = (state == ST_RUN) & ~bus.halt & ~bus.redirect_valid &
                       ((count < CNT_W'(DEPTH)) | deq);
   assign contended  = bus.dbg_req & fetch_want;

   // Under contention the side that did not win last time gets the port.
   always_comb begin
      fetch_gnt = 1'b0;
      dbg_gnt   = 1'b0;
      if (contended) begin
         if (last_gnt == GNT_FETCH) dbg_gnt   = 1'b1;
         else                       fetch_gnt = 1'b1;
      end else begin
         fetch_gnt = fetch_want;
         dbg_gnt   = bus.dbg_req & ~rst;
      end
   end

   assign redirect_aligned = bus.redirect_pc & ~32'd3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc         <= RESET_PC;
         last_gnt   <= GNT_FETCH;
         dbg_rvalid <= 1'b0;
         dbg_rdata  <= '0;
      end else begin
         if (bus.redirect_valid) pc <= redirect_aligned;
         else if (fetch_gnt)     pc <= pc + PC_INC;
         if (contended) last_gnt <= dbg_gnt ? GNT_DBG : GNT_FETCH;
         dbg_rvalid <= dbg_gnt;
         if (dbg_gnt) dbg_rdata <= bus.imem_data;
      end
   end

   fetch_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fetch_buf (
      .clk        (clk),
      .rst        (rst),
      .flush      (bus.redirect_valid),
      .enq        (fetch_gnt),
      .deq        (buf_deq),
      .enq_pc     (pc),
      .enq_data   (bus.imem_data),
      .count      (count),
      .head_valid (head_valid),
      .head_pc    (head_pc),
      .head_data  (head_data)
   );

   assign bus.imem_addr  = dbg_gnt ? bus.dbg_addr : pc[ADDR_W+1:2];
   assign bus.inst_valid = head_valid;
   assign bus.inst_pc    = head_pc;
   assign bus.inst_data  = head_data;
   assign bus.fetch_pc   = pc;
   assign bus.dbg_gnt    = dbg_gnt;
   assign bus.dbg_rvalid = dbg_rvalid;
   assign bus.dbg_rdata  = dbg_rdata;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Cycle-table bench for imem_fetch_ctrl with a memory that returns its own
// word address, followed by async-reset and restart streaming sequences.
module tb_imem_fetch_ctrl;
   import imem_fetch_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   imem_fetch_ctrl_if #(.ADDR_W(10), .DATA_W(32)) bus ();

   imem_fetch_ctrl #(
      .ADDR_W   (10),
      .DATA_W   (32),
      .RESET_PC (32'h0000_0000),
      .DEPTH    (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // mem[k] = k
   assign bus.imem_data = 32'(bus.imem_addr);

   typedef struct {
      logic        rst, halt, redir, ready, dreq;
      logic [31:0] rpc;
      logic [9:0]  daddr;
      logic        valid, chk_head;
      logic [31:0] ipc, idata, fpc;
      logic        gnt, rvalid;
      logic [31:0] rdata;
      logic [9:0]  addr;
   } vec_t;

   vec_t tbl [36];

   function automatic vec_t v(input int r, input int h, input int rd, input int rpc,
                              input int rdy, input int dq, input int da,
                              input int vl, input int ck, input int ipc, input int idt,
                              input int fpc, input int g, input int rv, input int rdt,
                              input int ad);
      vec_t x;
      x.rst = (r != 0);   x.halt = (h != 0);   x.redir = (rd != 0);
      x.rpc = 32'(rpc);   x.ready = (rdy != 0); x.dreq = (dq != 0);
      x.daddr = 10'(da);  x.valid = (vl != 0);  x.chk_head = (ck != 0);
      x.ipc = 32'(ipc);   x.idata = 32'(idt);   x.fpc = 32'(fpc);
      x.gnt = (g != 0);   x.rvalid = (rv != 0); x.rdata = 32'(rdt);
      x.addr = 10'(ad);
      return x;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      //            rst h rd rpc    rdy dq da      vl ck ipc     idata  fpc     g rv rdata  addr
      tbl[0]  = v(0, 0, 0, 0,     1, 0, 0,     0, 1, 0,     0,     0,      0, 0, 0,     0);
      tbl[1]  = v(0, 0, 0, 0,     1, 0, 0,     0, 1, 0,     0,     0,      0, 0, 0,     0);
      tbl[2]  = v(0, 0, 0, 0,     1, 0, 0,     1, 1, 0,     0,     4,      0, 0, 0,     1);
      tbl[3]  = v(0, 0, 0, 0,     0, 0, 0,     1, 1, 4,     1,     8,      0, 0, 0,     2);
      tbl[4]  = v(0, 0, 0, 0,     0, 0, 0,     1, 1, 4,     1,     12,     0, 0, 0,     3);
      tbl[5]  = v(0, 0, 0, 0,     0, 0, 0,     1, 1, 4,     1,     12,     0, 0, 0,     3);
      tbl[6]  = v(0, 0, 0, 0,     0, 0, 0,     1, 1, 4,     1,     12,     0, 0, 0,     3);
      tbl[7]  = v(0, 0, 0, 0,     0, 0, 0,     1, 1, 4,     1,     12,     0, 0, 0,     3);
      tbl[8]  = v(0, 0, 0, 0,     1, 0, 0,     1, 1, 4,     1,     12,     0, 0, 0,     3);
      tbl[9]  = v(0, 0, 0, 0,     1, 0, 0,     1, 1, 8,     2,     16,     0, 0, 0,     4);
      tbl[10] = v(0, 0, 1, 'h103, 1, 0, 0,     1, 1, 12,    3,     20,     0, 0, 0,     5);
      tbl[11] = v(0, 0, 0, 0,     1, 0, 0,     0, 0, 0,     0,     'h100,  0, 0, 0,     'h40);
      tbl[12] = v(0, 0, 0, 0,     1, 1, 'h3FF, 1, 1, 'h100, 'h40,  'h104,  1, 0, 0,     'h3FF);
      tbl[13] = v(0, 0, 0, 0,     1, 1, 'h3FF, 0, 0, 0,     0,     'h104,  0, 1, 'h3FF, 'h41);
      tbl[14] = v(0, 0, 0, 0,     1, 1, 'h3FF, 1, 1, 'h104, 'h41,  'h108,  1, 0, 'h3FF, 'h3FF);
      tbl[15] = v(0, 0, 0, 0,     1, 0, 0,     0, 0, 0,     0,     'h108,  0, 1, 'h3FF, 'h42);
      tbl[16] = v(0, 1, 0, 0,     0, 1, 'h3FF, 1, 1, 'h108, 'h42,  'h10C,  1, 0, 'h3FF, 'h3FF);
      tbl[17] = v(0, 1, 0, 0,     1, 1, 'h005, 1, 1, 'h108, 'h42,  'h10C,  1, 1, 'h3FF, 5);
      tbl[18] = v(0, 1, 0, 0,     1, 0, 0,     0, 0, 0,     0,     'h10C,  0, 1, 5,     'h43);
      tbl[19] = v(0, 0, 0, 0,     1, 0, 0,     0, 0, 0,     0,     'h10C,  0, 0, 5,     'h43);
      tbl[20] = v(0, 0, 0, 0,     1, 0, 0,     0, 0, 0,     0,     'h10C,  0, 0, 5,     'h43);
      tbl[21] = v(0, 0, 1, 'hFFE, 1, 0, 0,     1, 1, 'h10C, 'h43,  'h110,  0, 0, 5,     'h44);
      tbl[22] = v(0, 0, 0, 0,     1, 0, 0,     0, 0, 0,     0,     'hFFC,  0, 0, 5,     'h3FF);
      tbl[23] = v(0, 0, 0, 0,     1, 0, 0,     1, 1, 'hFFC, 'h3FF, 'h1000, 0, 0, 5,     0);
      tbl[24] = v(0, 0, 0, 0,     1, 0, 0,     1, 1, 'h1000, 0,    'h1004, 0, 0, 5,     1);
      tbl[25] = v(1, 0, 0, 0,     1, 1, 7,     0, 1, 0,     0,     0,      0, 0, 0,     0);
      tbl[26] = v(0, 0, 0, 0,     1, 1, 7,     0, 1, 0,     0,     0,      1, 0, 0,     7);
      tbl[27] = v(0, 1, 0, 0,     1, 0, 0,     0, 1, 0,     0,     0,      0, 1, 7,     0);
      tbl[28] = v(0, 1, 1, 'h200, 1, 0, 0,     0, 1, 0,     0,     0,      0, 0, 7,     0);
      tbl[29] = v(0, 0, 0, 0,     1, 0, 0,     0, 0, 0,     0,     'h200,  0, 0, 7,     'h80);
      tbl[30] = v(0, 0, 0, 0,     1, 0, 0,     0, 0, 0,     0,     'h200,  0, 0, 7,     'h80);
      tbl[31] = v(0, 0, 0, 0,     0, 1, 'h3FF, 1, 1, 'h200, 'h80,  'h204,  1, 0, 7,     'h3FF);
      tbl[32] = v(0, 0, 0, 0,     0, 1, 'h3FE, 1, 1, 'h200, 'h80,  'h204,  0, 1, 'h3FF, 'h81);
      tbl[33] = v(0, 0, 0, 0,     0, 1, 'h3FE, 1, 1, 'h200, 'h80,  'h208,  1, 0, 'h3FF, 'h3FE);
      tbl[34] = v(0, 0, 0, 0,     1, 0, 0,     1, 1, 'h200, 'h80,  'h208,  0, 1, 'h3FE, 'h82);
      tbl[35] = v(0, 0, 0, 0,     1, 0, 0,     1, 1, 'h204, 'h81,  'h20C,  0, 0, 'h3FE, 'h83);

      bus.halt = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
      bus.inst_ready = 1'b0; bus.dbg_req = 1'b0; bus.dbg_addr = '0;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 36; i++) begin
         rst                = tbl[i].rst;
         bus.halt           = tbl[i].halt;
         bus.redirect_valid = tbl[i].redir;
         bus.redirect_pc    = tbl[i].rpc;
         bus.inst_ready     = tbl[i].ready;
         bus.dbg_req        = tbl[i].dreq;
         bus.dbg_addr       = tbl[i].daddr;
         @(negedge clk);
         check($sformatf("row%0d inst_valid", i), 32'(bus.inst_valid), 32'(tbl[i].valid));
         if (tbl[i].chk_head) begin
            check($sformatf("row%0d inst_pc", i), bus.inst_pc, tbl[i].ipc);
            check($sformatf("row%0d inst_data", i), bus.inst_data, tbl[i].idata);
         end
         check($sformatf("row%0d fetch_pc", i), bus.fetch_pc, tbl[i].fpc);
         check($sformatf("row%0d dbg_gnt", i), 32'(bus.dbg_gnt), 32'(tbl[i].gnt));
         check($sformatf("row%0d dbg_rvalid", i), 32'(bus.dbg_rvalid), 32'(tbl[i].rvalid));
         check($sformatf("row%0d dbg_rdata", i), bus.dbg_rdata, tbl[i].rdata);
         check($sformatf("row%0d imem_addr", i), 32'(bus.imem_addr), 32'(tbl[i].addr));
         @(posedge clk);
         #1;
      end

      // Buffer is full with dbg_rdata=0x3FE; reset mid-cycle must clear at once.
      bus.inst_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("async inst_valid", 32'(bus.inst_valid), 32'd0);
      check("async inst_pc", bus.inst_pc, 32'd0);
      check("async inst_data", bus.inst_data, 32'd0);
      check("async fetch_pc", bus.fetch_pc, 32'd0);
      check("async dbg_rdata", bus.dbg_rdata, 32'd0);
      check("async dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.inst_ready = 1'b1;
      n = 0;
      while (!bus.inst_valid && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("restart edges to inst_valid", 32'(n), 32'd2);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("stream%0d inst_valid", k), 32'(bus.inst_valid), 32'd1);
         check($sformatf("stream%0d inst_pc", k), bus.inst_pc, 32'(4 * k));
         check($sformatf("stream%0d inst_data", k), bus.inst_data, 32'(k));
         @(posedge clk);
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
